mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, 1024, number of 32-bit words in the backing array.
REQ-002 Parameter WAIT_CYCLES, 2, wait-state cycles inserted between request acceptance and access; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk; reset==0 resets.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_wstrb  input  4  byte enables for writes; bit i covers wdata[8i+7:8i].
REQ-010 req_wdata  input  32  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  access was misaligned or out of range.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE; busy SHALL be the inverse of req_ready.
REQ-017 Handshake: a request is accepted on the rising edge where req_valid==1 and req_ready==1; req_addr, req_we, req_wstrb and req_wdata SHALL be latched on that edge and ignored afterwards.
REQ-018 On acceptance with WAIT_CYCLES==0, the next state SHALL be RESP; otherwise it SHALL be WAIT with the wait counter loaded to WAIT_CYCLES-1.
REQ-019 In WAIT, the counter SHALL decrement by 1 per cycle; on the cycle it reads 0, the access SHALL be performed and the next state SHALL be RESP.
REQ-020 Latency: rsp_valid SHALL first be 1 exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-021 Error: rsp_err SHALL be 1 when latched addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; on error no array write occurs and rsp_rdata SHALL be 0.
REQ-022 Read: rsp_rdata SHALL equal the array word at addr[31:2] as of the access cycle.
REQ-023 Write: only bytes with wstrb bit set SHALL be updated; wstrb==0 SHALL be a legal no-op write with rsp_err=0.
REQ-024 The array write SHALL commit on the same edge that enters RESP, and never earlier.
REQ-025 In RESP, rsp_valid=1; rsp_rdata and rsp_err SHALL hold stable until the edge where rsp_ready==1, after which the next state SHALL be IDLE with rsp_valid=0.
REQ-026 rsp_ready asserted outside RESP SHALL have no effect.
REQ-027 Back-to-back: a new request SHALL NOT be accepted in the cycle its predecessor's response is consumed; minimum spacing between acceptances is WAIT_CYCLES+2 cycles.
REQ-028 req_valid deasserting while not ready SHALL NOT be an error; no request is recorded.

Reset
REQ-029 On reset==0 at a rising edge: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, so req_ready=1 and busy=0 in the following cycle.
REQ-030 Reset in WAIT SHALL abandon the transaction with no array write; reset in RESP SHALL drop the pending response.
REQ-031 Reset SHALL NOT clear the backing array; its contents are undefined until written.
REQ-032 Reset SHALL take priority over a simultaneous request acceptance, access or response handshake.

Verification
REQ-033 WAIT_CYCLES=2: write 0xDEADBEEF, wstrb=4'hF, addr 0x10; then read 0x10 -> rsp_valid 3 cycles after each acceptance, rdata=0xDEADBEEF, err=0.
REQ-034 Partial write wstrb=4'b0101, wdata 0x11223344 over 0xDEADBEEF at 0x10; read -> rdata=0xDE22BE44.
REQ-035 Read 0x12 (misaligned), then read 4*DEPTH_WORDS (out of range), then write 0x0 with err expected 0 -> first two give err=1 and rdata=0; prior array contents unchanged.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stable, req_ready=0 throughout; ack -> IDLE next cycle.
REQ-037 Assert reset=0 one cycle after accepting a write to 0x20 (in WAIT) -> IDLE, rsp_valid=0, and a later read of 0x20 returns its pre-write value.
REQ-038 WAIT_CYCLES=0 with req_valid held high and rsp_ready=1 -> acceptances every 2 cycles, rsp_valid 1 cycle after each.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-outstanding valid/ready memory responder with a
//               byte-strobed 32-bit backing array and programmable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int          c_IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] c_DEPTH     = 30'(DEPTH_WORDS);
  localparam bit          c_NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0]  c_WAIT_LOAD = c_NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_access;
  logic [3:0]           r_cnt;

  logic [31:0]          r_addr;
  logic                 r_we;
  logic [3:0]           r_wstrb;
  logic [31:0]          r_wdata;

  logic [31:0]          r_mem [DEPTH_WORDS];

  logic                 w_from_req;
  logic [31:0]          w_acc_addr;
  logic                 w_acc_we;
  logic [3:0]           w_acc_wstrb;
  logic [31:0]          w_acc_wdata;
  logic                 w_err;
  logic [c_IDX_W-1:0]   w_idx;
  logic                 w_mem_we;
  logic                 w_accept;

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = (r_state == ST_RESP);
  assign w_accept  = req_valid && req_ready;

  // With zero wait states the access happens on the accepting edge itself,
  // so the access path must see the live request rather than the latched copy.
  assign w_from_req  = (r_state == ST_IDLE);
  assign w_acc_addr  = w_from_req ? req_addr  : r_addr;
  assign w_acc_we    = w_from_req ? req_we    : r_we;
  assign w_acc_wstrb = w_from_req ? req_wstrb : r_wstrb;
  assign w_acc_wdata = w_from_req ? req_wdata : r_wdata;

  assign w_err    = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr[31:2] >= c_DEPTH);
  assign w_idx    = w_acc_addr[c_IDX_W+1:2];
  assign w_mem_we = w_access && w_acc_we && !w_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_access     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (c_NO_WAIT) begin
            w_next_state = ST_RESP;
            w_access     = 1'b1;
          end else begin
            w_next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = ST_RESP;
          w_access     = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_we    <= 1'b0;
      r_wstrb <= 4'd0;
      r_wdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_cnt   <= c_WAIT_LOAD;
        r_addr  <= req_addr;
        r_we    <= req_we;
        r_wstrb <= req_wstrb;
        r_wdata <= req_wdata;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (w_access) begin
      rsp_rdata <= (w_err || w_acc_we) ? 32'd0 : r_mem[w_idx];
      rsp_err   <= w_err;
    end else if ((r_state == ST_RESP) && rsp_ready) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end
  end

  // The array has no reset; reset only suppresses a write on the same edge.
  always_ff @(posedge clk) begin
    if (reset && w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed self-checking bench for mem_responder (2 and 0 waits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic        req_we = 1'b0;
  logic [3:0]  req_wstrb = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic [31:0] z_req_addr = 32'd0;
  logic        z_req_we = 1'b0;
  logic [3:0]  z_req_wstrb = 4'd0;
  logic [31:0] z_req_wdata = 32'd0;
  logic        z_rsp_valid;
  logic        z_rsp_ready = 1'b0;
  logic [31:0] z_rsp_rdata;
  logic        z_rsp_err;
  logic        z_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
    .req_we(z_req_we), .req_wstrb(z_req_wstrb), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .busy(z_busy)
  );

  // Issue one request from a negedge, scramble inputs after acceptance,
  // report cycles-to-response (99 on timeout), then acknowledge it.
  task automatic do_req(input logic [31:0] a, input logic we, input logic [3:0] s,
                        input logic [31:0] d, output int lat,
                        output logic [31:0] rd, output logic e);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wstrb = s; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_we = ~we; req_wstrb = ~s; req_wdata = ~d;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = 99;
    rd = rsp_rdata;
    e  = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_data got=%h/%b exp=0/0", rsp_rdata, rsp_err); end
    checks++; if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_dut0 got ready=%b valid=%b exp=1/0", z_req_ready, z_rsp_valid); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic e;
    do_req(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, lat, rd, e);
    checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    checks++; if (e !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL wr_rsp got=%h/%b exp=0/0", rd, e); end
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_idle got ready=%b valid=%b exp=1/0", req_ready, rsp_valid); end
    do_req(32'h10, 1'b0, 4'h0, 32'h0, lat, rd, e);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin failures++; $display("FAIL rd_data got=%h/%b exp=deadbeef/0", rd, e); end
  endtask

  task automatic test_partial_write();
    int lat; logic [31:0] rd; logic e;
    do_req(32'h10, 1'b1, 4'b0101, 32'h1122_3344, lat, rd, e);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL partial_wr_err got=%b exp=0", e); end
    do_req(32'h10, 1'b0, 4'h0, 32'h0, lat, rd, e);
    checks++; if (rd !== 32'hDE22_BE44) begin failures++; $display("FAIL partial_rd got=%h exp=de22be44", rd); end
    do_req(32'h10, 1'b1, 4'b0000, 32'h5555_5555, lat, rd, e);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL nostrb_err got=%b exp=0", e); end
    do_req(32'h10, 1'b0, 4'h0, 32'h0, lat, rd, e);
    checks++; if (rd !== 32'hDE22_BE44) begin failures++; $display("FAIL nostrb_rd got=%h exp=de22be44", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic e;
    do_req(32'h12, 1'b0, 4'h0, 32'h0, lat, rd, e);
    checks++; if (e !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL misalign_rd got=%h/%b exp=0/1", rd, e); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL err_latency got=%0d exp=3", lat); end
    do_req(32'h1000, 1'b0, 4'h0, 32'h0, lat, rd, e);
    checks++; if (e !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL range_rd got=%h/%b exp=0/1", rd, e); end
    do_req(32'h0, 1'b1, 4'hF, 32'hCAFE_F00D, lat, rd, e);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL wr0_err got=%b exp=0", e); end
    // Faulty writes whose low index bits alias word 4 (address 0x10)
    do_req(32'h11, 1'b1, 4'hF, 32'hFFFF_FFFF, lat, rd, e);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL misalign_wr_err got=%b exp=1", e); end
    do_req(32'h1010, 1'b1, 4'hF, 32'hFFFF_FFFF, lat, rd, e);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL range_wr_err got=%b exp=1", e); end
    do_req(32'h10, 1'b0, 4'h0, 32'h0, lat, rd, e);
    checks++; if (rd !== 32'hDE22_BE44) begin failures++; $display("FAIL err_nowrite got=%h exp=de22be44", rd); end
    do_req(32'h0, 1'b0, 4'h0, 32'h0, lat, rd, e);
    checks++; if (rd !== 32'hCAFE_F00D || e !== 1'b0) begin failures++; $display("FAIL rd0 got=%h/%b exp=cafef00d/0", rd, e); end
  endtask

  task automatic test_hold();
    int n;
    req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b0; req_wstrb = 4'h0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (n !== 3) begin failures++; $display("FAIL hold_latency got=%0d exp=3", n); end
    // Keep req_valid high to show it is ignored while busy
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22_BE44 || rsp_err !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got v=%b d=%h e=%b rdy=%b busy=%b exp 1/de22be44/0/0/1",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, busy);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL hold_ack got v=%b rdy=%b exp 0/1", rsp_valid, req_ready); end
    repeat (4) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL no_phantom_req got v=%b busy=%b exp 0/0", rsp_valid, busy); end
  endtask

  task automatic test_early_ready();
    int n;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0; req_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (n !== 3 || rsp_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL early_ready got lat=%0d d=%h exp 3/cafef00d", n, rsp_rdata); end
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL early_ready_idle got v=%b rdy=%b exp 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic e;
    do_req(32'h20, 1'b1, 4'hF, 32'h1234_5678, lat, rd, e);
    req_valid = 1'b1; req_addr = 32'h20; req_we = 1'b1; req_wstrb = 4'hF; req_wdata = 32'hAAAA_AAAA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_wait got rdy=%b v=%b busy=%b exp 1/0/0", req_ready, rsp_valid, busy); end
    repeat (4) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_wait_norsp got=%b exp=0", rsp_valid); end
    do_req(32'h20, 1'b0, 4'h0, 32'h0, lat, rd, e);
    checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL rst_wait_nowrite got=%h exp=12345678", rd); end
    // Reset while a response is pending
    req_valid = 1'b1; req_addr = 32'h20; req_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rst_resp_pre got=%b exp=1", rsp_valid); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'd0) begin failures++; $display("FAIL rst_resp got v=%b rdy=%b d=%h exp 0/1/0", rsp_valid, req_ready, rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    int accepts;
    int n;
    z_rsp_ready = 1'b1;
    z_req_valid = 1'b1; z_req_addr = 32'h4; z_req_we = 1'b1; z_req_wstrb = 4'hF; z_req_wdata = 32'h0BAD_F00D;
    accepts = 0;
    for (int k = 1; k <= 8; k++) begin
      if (z_req_ready) accepts++;
      @(negedge clk);
      checks++;
      if (z_rsp_valid !== logic'(k % 2) || z_req_ready !== logic'(1 - (k % 2))) begin
        failures++;
        $display("FAIL b2b cyc=%0d got v=%b rdy=%b exp %0d/%0d", k, z_rsp_valid, z_req_ready, k % 2, 1 - (k % 2));
      end
    end
    checks++; if (accepts !== 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", accepts); end
    z_req_valid = 1'b0;
    z_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    z_req_valid = 1'b0;
    n = 1;
    while (!z_rsp_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (n !== 1 || z_rsp_rdata !== 32'h0BAD_F00D || z_rsp_err !== 1'b0) begin failures++; $display("FAIL z_read got lat=%0d d=%h e=%b exp 1/0badf00d/0", n, z_rsp_rdata, z_rsp_err); end
    z_rsp_ready = 1'b1;
    @(negedge clk);
    z_rsp_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_partial_write();
    test_errors();
    test_hold();
    test_early_ready();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
